// File: rtl/flag_pkg.sv
// Shared constants, flag bit positions and elaboration-time sizing helpers for flag_pipe.
// The helpers derive per-level lane widths and their offsets in the flattened lane vectors.
package flag_pkg;

    localparam int unsigned FLAG_Z    = 0;
    localparam int unsigned FLAG_EQ   = 1;
    localparam int unsigned FLAG_ONES = 2;
    localparam int unsigned FLAG_NEG  = 3;
    localparam int unsigned FLAGS_W   = 4;

    function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
        return (n + d - 1) / d;
    endfunction

    // Number of FANIN-input AND levels needed to collapse WIDTH bits to one (minimum 1).
    function automatic int unsigned calc_levels(input int unsigned width, input int unsigned fanin);
        int unsigned n;
        int unsigned lv;
        n  = ceil_div(width, fanin);
        lv = 1;
        while (n > 1) begin
            n  = ceil_div(n, fanin);
            lv = lv + 1;
        end
        return lv;
    endfunction

    // Lane width entering level k (k = 0 is the raw per-bit terms).
    function automatic int unsigned level_width(input int unsigned width, input int unsigned fanin,
                                                input int unsigned k);
        int unsigned n;
        n = width;
        for (int unsigned i = 0; i < k; i++) begin
            n = ceil_div(n, fanin);
        end
        return n;
    endfunction

    function automatic int unsigned level_offset(input int unsigned width, input int unsigned fanin,
                                                 input int unsigned k);
        int unsigned off;
        off = 0;
        for (int unsigned i = 0; i < k; i++) begin
            off = off + level_width(width, fanin, i);
        end
        return off;
    endfunction

endpackage

// File: rtl/flag_pipe_if.sv
// Operand/flag handshake bundle between the ALU result register and the flag pipeline.
interface flag_pipe_if
    import flag_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic [WIDTH-1:0]   in_mask;
    logic               out_valid;
    logic               out_ready;
    logic [FLAGS_W-1:0] out_flags;
    logic               sticky_zero;
    logic               sticky_clr;

    modport master (
        output in_valid, in_a, in_b, in_mask, out_ready, sticky_clr,
        input  in_ready, out_valid, out_flags, sticky_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mask, out_ready, sticky_clr,
        output in_ready, out_valid, out_flags, sticky_zero
    );

endinterface

// File: rtl/and_reduce_stage.sv
// One registered AND-tree level: reduces three lanes by FANIN (short groups padded with 1),
// carries the sign bit and valid bit alongside, and holds everything while i_en is low.
module and_reduce_stage
    import flag_pkg::*;
#(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned FANIN = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_en,
    input  logic                             i_valid,
    input  logic [IN_W-1:0]                  i_z,
    input  logic [IN_W-1:0]                  i_e,
    input  logic [IN_W-1:0]                  i_o,
    input  logic                             i_neg,
    output logic                             o_valid,
    output logic [ceil_div(IN_W, FANIN)-1:0] o_z,
    output logic [ceil_div(IN_W, FANIN)-1:0] o_e,
    output logic [ceil_div(IN_W, FANIN)-1:0] o_o,
    output logic                             o_neg
);
    localparam int unsigned OUT_W = ceil_div(IN_W, FANIN);
    localparam int unsigned PAD_W = OUT_W * FANIN;

    logic [PAD_W-1:0] w_z_pad, w_e_pad, w_o_pad;
    logic [OUT_W-1:0] w_z_red, w_e_red, w_o_red;
    logic [OUT_W-1:0] r_z, r_e, r_o;
    logic             r_valid, r_neg;

    // Pad the top group with the AND identity so partial groups reduce correctly.
    always_comb begin
        w_z_pad             = '1;
        w_e_pad             = '1;
        w_o_pad             = '1;
        w_z_pad[IN_W-1:0]   = i_z;
        w_e_pad[IN_W-1:0]   = i_e;
        w_o_pad[IN_W-1:0]   = i_o;
    end

    for (genvar j = 0; j < OUT_W; j++) begin : g_node
        assign w_z_red[j] = &w_z_pad[j*FANIN +: FANIN];
        assign w_e_red[j] = &w_e_pad[j*FANIN +: FANIN];
        assign w_o_red[j] = &w_o_pad[j*FANIN +: FANIN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_z     <= '0;
            r_e     <= '0;
            r_o     <= '0;
            r_neg   <= 1'b0;
        end else if (i_en) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_z   <= w_z_red;
                r_e   <= w_e_red;
                r_o   <= w_o_red;
                r_neg <= i_neg;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_z     = r_z;
    assign o_e     = r_e;
    assign o_o     = r_o;
    assign o_neg   = r_neg;

endmodule

// File: rtl/flag_pipe.sv
// Pipelined zero/equal/all-ones/negative flag reducer with valid/ready handshakes
// and a sticky-zero accumulator for multi-word compares.
module flag_pipe
    import flag_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned FANIN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    flag_pipe_if.slave bus
);
    localparam int unsigned LEVELS = calc_levels(WIDTH, FANIN);
    localparam int unsigned TOT_W  = level_offset(WIDTH, FANIN, LEVELS) + 1;

    // Lane vectors hold every level back to back; level k sits at level_offset(k).
    logic [TOT_W-1:0] w_z, w_e, w_o;
    logic [LEVELS:0]  w_vld, w_neg;
    logic             w_stall;
    logic             w_adv;
    logic             w_out_xfer;
    logic             w_zero_out;
    logic             r_sticky_zero;

    // Per-bit terms; masked-off bits read as true in every lane.
    assign w_z[WIDTH-1:0] = ~bus.in_a | ~bus.in_mask;
    assign w_e[WIDTH-1:0] = ~(bus.in_a ^ bus.in_b) | ~bus.in_mask;
    assign w_o[WIDTH-1:0] = bus.in_a | ~bus.in_mask;
    assign w_neg[0]       = bus.in_a[WIDTH-1];
    assign w_vld[0]       = bus.in_valid;

    assign w_stall    = w_vld[LEVELS] & ~bus.out_ready;
    assign w_adv      = ~w_stall;
    assign w_out_xfer = w_vld[LEVELS] & bus.out_ready;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int unsigned IN_OFF  = level_offset(WIDTH, FANIN, k);
        localparam int unsigned IN_W    = level_width(WIDTH, FANIN, k);
        localparam int unsigned OUT_OFF = level_offset(WIDTH, FANIN, k + 1);
        localparam int unsigned OUT_W   = level_width(WIDTH, FANIN, k + 1);

        and_reduce_stage #(
            .IN_W  (IN_W),
            .FANIN (FANIN)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_en    (w_adv),
            .i_valid (w_vld[k]),
            .i_z     (w_z[IN_OFF +: IN_W]),
            .i_e     (w_e[IN_OFF +: IN_W]),
            .i_o     (w_o[IN_OFF +: IN_W]),
            .i_neg   (w_neg[k]),
            .o_valid (w_vld[k+1]),
            .o_z     (w_z[OUT_OFF +: OUT_W]),
            .o_e     (w_e[OUT_OFF +: OUT_W]),
            .o_o     (w_o[OUT_OFF +: OUT_W]),
            .o_neg   (w_neg[k+1])
        );
    end

    assign w_zero_out = w_z[TOT_W-1];

    // A clear coinciding with a transfer starts the new accumulation with that transfer's flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky_zero <= 1'b1;
        end else if (w_out_xfer) begin
            r_sticky_zero <= (bus.sticky_clr | r_sticky_zero) & w_zero_out;
        end else if (bus.sticky_clr) begin
            r_sticky_zero <= 1'b1;
        end
    end

    assign bus.in_ready             = ~w_stall;
    assign bus.out_valid            = w_vld[LEVELS];
    assign bus.out_flags[FLAG_Z]    = w_zero_out;
    assign bus.out_flags[FLAG_EQ]   = w_e[TOT_W-1];
    assign bus.out_flags[FLAG_ONES] = w_o[TOT_W-1];
    assign bus.out_flags[FLAG_NEG]  = w_neg[LEVELS];
    assign bus.sticky_zero          = r_sticky_zero;

endmodule
